// File: rtl/pattern_detector_pkg.sv
// Shared constants and types for the serial pattern detector.
package pattern_detector_pkg;

    // Build-time defaults for the detector and its match counter.
    localparam int unsigned DEF_PAT_LEN = 3;
    localparam int unsigned DEF_CNT_W   = 8;
    localparam logic [DEF_PAT_LEN-1:0] DEF_RST_PAT = 3'b100;

    // What a given clock edge does to the detector state.
    typedef enum logic [1:0] {
        ActHold  = 2'b00,
        ActShift = 2'b01,
        ActLoad  = 2'b10
    } action_e;

endpackage

// File: rtl/pattern_detector_if.sv
// Data/control bundle between a bit-stream source and the pattern detector.
interface pattern_detector_if
    import pattern_detector_pkg::*;
#(
    parameter int unsigned PAT_LEN = DEF_PAT_LEN,
    parameter int unsigned CNT_W   = DEF_CNT_W
) ();

    logic               x;
    logic               x_valid;
    logic               overlap;
    logic               pat_load;
    logic [PAT_LEN-1:0] pat_in;
    logic               y;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output x, x_valid, overlap, pat_load, pat_in,
        input  y, match_count
    );

    modport slave (
        input  x, x_valid, overlap, pat_load, pat_in,
        output y, match_count
    );

endinterface

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter; sticks at all-ones once reached.
module pattern_detector_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count increments, holding at the maximum value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector with loadable pattern, overlap control and Moore match pulse.
// Match counter is built only when PATTERN_DETECTOR_COUNT_EN is defined; otherwise
// match_count is tied to zero.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
    parameter int unsigned        CNT_W   = DEF_CNT_W,
    parameter logic [PAT_LEN-1:0] RST_PAT = PAT_LEN'(DEF_RST_PAT)
) (
    input logic               clk,
    input logic               reset,
    pattern_detector_if.slave bus
);

    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [PAT_LEN-1:0] r_pat;
    logic               r_y;

    action_e            w_action;
    logic [PAT_LEN-1:0] w_hist_shift;
    logic [FILL_W-1:0]  w_fill_inc;
    logic               w_match;
    logic [PAT_LEN-1:0] w_hist_nxt;
    logic [FILL_W-1:0]  w_fill_nxt;
    logic [PAT_LEN-1:0] w_pat_nxt;
    logic               w_y_nxt;

    // Decode the edge action (pattern load beats data) and the match condition.
    always_comb begin
        w_action = ActHold;
        if (bus.pat_load) begin
            w_action = ActLoad;
        end else if (bus.x_valid) begin
            w_action = ActShift;
        end
        w_hist_shift = {r_hist[PAT_LEN-2:0], bus.x};
        w_fill_inc   = (r_fill == FILL_FULL) ? r_fill : r_fill + 1'b1;
        w_match      = (w_action == ActShift) && (w_fill_inc == FILL_FULL) &&
                       (w_hist_shift == r_pat);
    end

    // Next-state for history, fill level, pattern and match pulse.
    always_comb begin
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        w_pat_nxt  = r_pat;
        w_y_nxt    = 1'b0;
        unique case (w_action)
            ActLoad: begin
                w_pat_nxt  = bus.pat_in;
                w_fill_nxt = '0;
            end
            ActShift: begin
                w_hist_nxt = w_hist_shift;
                // Non-overlapping mode restarts the window after a hit.
                w_fill_nxt = (w_match && !bus.overlap) ? '0 : w_fill_inc;
                w_y_nxt    = w_match;
            end
            default: begin
            end
        endcase
    end

    // Detector state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= RST_PAT;
            r_y    <= 1'b0;
        end else begin
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            r_pat  <= w_pat_nxt;
            r_y    <= w_y_nxt;
        end
    end

    assign bus.y = r_y;

`ifdef PATTERN_DETECTOR_COUNT_EN
    logic [CNT_W-1:0] w_count;

    pattern_detector_sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk     (clk),
        .reset   (reset),
        .inc     (w_match),
        .o_count (w_count)
    );

    assign bus.match_count = w_count;
`else
    assign bus.match_count = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter PAT_LEN, default 3, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL have parameter RST_PAT, default PAT_LEN'b100, pattern active after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port x  input  1  serial data bit.
REQ-007 SHALL have port x_valid  input  1  x is accepted only on edges where x_valid=1.
REQ-008 SHALL have port overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port pat_load  input  1  latch pat_in as the new pattern.
REQ-010 SHALL have port pat_in  input  PAT_LEN  new pattern; MSB is the first bit in time.
REQ-011 SHALL have port y  output  1  registered match pulse (Moore).
REQ-012 SHALL have port match_count  output  CNT_W  saturating count of matches.

Function
REQ-013 SHALL shift each accepted bit into history hist[PAT_LEN-1:0] at the LSB end: hist <= {hist[PAT_LEN-2:0], x}.
REQ-014 SHALL keep fill counter 0..PAT_LEN that increments per accepted bit and saturates at PAT_LEN.
REQ-015 SHALL detect a match on an accepted bit when next fill == PAT_LEN and next hist == stored pattern.
REQ-016 SHALL assert y for exactly one cycle, in the cycle after the edge that accepted the final matching bit (latency 1), otherwise 0.
REQ-017 SHALL clear fill to 0 on a match when overlap=0; SHALL leave fill at PAT_LEN when overlap=1.
REQ-018 SHALL apply a change of overlap from the next accepted bit; no retroactive effect.
REQ-019 SHALL hold hist, fill and y=0 on edges with x_valid=0 and no pat_load.
REQ-020 SHALL, on pat_load=1, latch pat_in, clear fill to 0 and drive y=0 next cycle.
REQ-021 SHALL discard x when pat_load and x_valid are both 1 on the same edge (pat_load wins).
REQ-022 SHALL increment match_count on each match and saturate at 2^CNT_W-1; pat_load SHALL NOT clear it.

Reset
REQ-023 SHALL, on reset=1 at an edge, set hist=0, fill=0, pattern=RST_PAT, y=0, match_count=0.
REQ-024 SHALL give reset priority over pat_load and x_valid; partial sequences in progress are lost.

Configuration
REQ-025 SHALL implement the counter only when PATTERN_DETECTOR_COUNT_EN is defined; the port SHALL remain present.
REQ-026 SHALL, without PATTERN_DETECTOR_COUNT_EN, drive match_count constant 0 with no counter flops; y is unaffected.

Structure
REQ-027 SHALL place default PAT_LEN, default CNT_W and default RST_PAT constants in shared package pattern_detector_pkg.
REQ-028 SHALL implement the saturating counter as sub-module pattern_detector_sat_counter (parameter CNT_W, inputs clk, reset, inc).

Verification
REQ-029 SHALL verify defaults, overlap=0, x=1,0,0 on consecutive valid cycles -> y=1 one cycle after third edge only, match_count=1.
REQ-030 SHALL verify pat_in=101 loaded, x=1,0,1,0,1: overlap=1 -> two y pulses (after bits 3 and 5); overlap=0 -> one pulse.
REQ-031 SHALL verify x=1,0,0 with x_valid=0 idle cycles between bits -> single y pulse after third valid bit.
REQ-032 SHALL verify pat_load with x_valid=1 after 1,0 of pattern 100 -> that x is dropped, no y until three new bits 1,0,0.
REQ-033 SHALL verify CNT_W=2 with five matches -> match_count=3; build without macro -> match_count=0 throughout.
REQ-034 SHALL verify reset after x=1,0 then x=0 -> y stays 0, match_count=0.
